// File: rtl/apb_bank_pkg.sv
// Shared types and constants for the APB register-bank back end.
package apb_bank_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_ACK  = 2'd1,
      RD_WAIT = 2'd2,
      RD_RESP = 2'd3
   } state_t;

   localparam logic [31:0] ID_VALUE_DEF = 32'hA0B5_0001;

   function automatic int idx_w(input int num_regs);
      return $clog2(num_regs);
   endfunction

endpackage

// File: rtl/apb_bank_regfile.sv
// Word-register storage: one write port, one combinational read port, word 1 exported.
module apb_bank_regfile
   import apb_bank_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = idx_w(NUM_REGS)
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_ridx,
   output logic [DATA_W-1:0] o_rdata,
   output logic [DATA_W-1:0] o_ctrl
);

   logic [DATA_W-1:0] word_arr [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
         logic [DATA_W-1:0] word_q;
         logic [DATA_W-1:0] word_d;

         always_comb begin
            word_d = word_q;
            if (i_we && (i_widx == IDX_W'(gi))) begin
               word_d = i_wdata;
            end
         end

         always_ff @(posedge i_clk) begin
            if (!i_rstn) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign word_arr[gi] = word_q;
      end
   endgenerate

   assign o_rdata = word_arr[i_ridx];
   assign o_ctrl  = word_arr[1];

endmodule

// File: rtl/apb_reg_bank.sv
// APB register-bank back end: command FSM, read wait-state counter and response muxing.
module apb_reg_bank
   import apb_bank_pkg::*;
#(
   parameter int               DATA_W   = 32,
   parameter int               ADDR_W   = 32,
   parameter int               NUM_REGS = 16,
   parameter int               RD_LAT   = 1,
   parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEF
) (
   input  logic              i_clk_apb,
   input  logic              i_rstn_apb,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_rd0_wr1,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_ready,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_addr_err,
   output logic [DATA_W-1:0] o_ctrl
);

   localparam int IDX_W = idx_w(NUM_REGS);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               oor_q, oor_d;
   logic               addr_err_q, addr_err_d;

   logic               accept;
   logic [IDX_W-1:0]   cmd_idx;
   logic               cmd_oor;
   logic               wr_en;
   logic [DATA_W-1:0]  reg_rdata;
   logic               unused_addr_lsbs;

   assign unused_addr_lsbs = ^i_addr[1:0];

   assign cmd_idx = i_addr[2+IDX_W-1:2];
   assign cmd_oor = |i_addr[ADDR_W-1:2+IDX_W];
   assign accept  = i_valid && o_ready;
   // The ID word and out-of-range targets swallow the write silently.
   assign wr_en   = accept && i_rd0_wr1 && !cmd_oor && (cmd_idx != '0);

   apb_bank_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .i_clk   (i_clk_apb),
      .i_rstn  (i_rstn_apb),
      .i_we    (wr_en),
      .i_widx  (cmd_idx),
      .i_wdata (i_wr_data),
      .i_ridx  (idx_q),
      .o_rdata (reg_rdata),
      .o_ctrl  (o_ctrl)
   );

   always_ff @(posedge i_clk_apb) begin
      if (!i_rstn_apb) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         oor_q      <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         oor_q      <= oor_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      oor_d      = oor_q;
      addr_err_d = accept && cmd_oor;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (i_rd0_wr1) begin
                  state_d = WR_ACK;
               end else begin
                  idx_d   = cmd_idx;
                  oor_d   = cmd_oor;
                  cnt_d   = 4'(RD_LAT);
                  state_d = (RD_LAT > 0) ? RD_WAIT : RD_RESP;
               end
            end
         end
         WR_ACK:  state_d = IDLE;
         RD_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = RD_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RD_RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ready is forced low while reset is held so nothing is accepted then.
   always_comb begin
      o_ready    = (state_q == IDLE) && i_rstn_apb;
      o_rd_valid = (state_q == RD_RESP);
      o_addr_err = addr_err_q;
      o_rd_data  = '0;
      if (o_rd_valid && !oor_q) begin
         o_rd_data = (idx_q == '0) ? ID_VALUE : reg_rdata;
      end
   end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_apb_reg_bank;

   localparam logic [31:0] ID = 32'hA0B5_0001;

   logic        clk = 1'b0;
   logic        rstn;
   logic        valid, rd0_wr1;
   logic [31:0] addr, wdata;
   logic        ready, rd_valid, addr_err;
   logic [31:0] rd_data, ctrl;

   logic        valid3, rd0_wr13;
   logic [31:0] addr3, wdata3;
   logic        ready3, rd_valid3, addr_err3;
   logic [31:0] rd_data3, ctrl3;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   apb_reg_bank #(.RD_LAT(1)) dut (
      .i_clk_apb  (clk),
      .i_rstn_apb (rstn),
      .i_valid    (valid),
      .i_addr     (addr),
      .i_rd0_wr1  (rd0_wr1),
      .i_wr_data  (wdata),
      .o_ready    (ready),
      .o_rd_valid (rd_valid),
      .o_rd_data  (rd_data),
      .o_addr_err (addr_err),
      .o_ctrl     (ctrl)
   );

   apb_reg_bank #(.RD_LAT(3)) dut3 (
      .i_clk_apb  (clk),
      .i_rstn_apb (rstn),
      .i_valid    (valid3),
      .i_addr     (addr3),
      .i_rd0_wr1  (rd0_wr13),
      .i_wr_data  (wdata3),
      .o_ready    (ready3),
      .o_rd_valid (rd_valid3),
      .o_rd_data  (rd_data3),
      .o_addr_err (addr_err3),
      .o_ctrl     (ctrl3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, got);
      end
   endtask

   // Write on the RD_LAT=1 instance; checks the one-cycle ready gap and error pulse.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
      chk("wr_ready_idle", 32'(ready), 32'd1);
      valid = 1'b1; rd0_wr1 = 1'b1; addr = a; wdata = d;
      tick();
      chk("wr_ack_ready", 32'(ready), 32'd0);
      chk("wr_addr_err", 32'(addr_err), 32'(exp_err));
      tick();
      valid = 1'b0;
      chk("wr_ready_back", 32'(ready), 32'd1);
      chk("wr_err_clear", 32'(addr_err), 32'd0);
   endtask

   // Read on the RD_LAT=1 instance; valid dropped right after accept.
   task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
      int n;
      chk("rd_ready_idle", 32'(ready), 32'd1);
      valid = 1'b1; rd0_wr1 = 1'b0; addr = a;
      tick();
      valid = 1'b0;
      n = 1;
      chk("rd_addr_err", 32'(addr_err), 32'(exp_err));
      while (!rd_valid && n < 20) begin
         tick();
         n++;
      end
      chk("rd_latency", 32'(n), 32'd2);
      chk("rd_data", rd_data, exp_d);
      tick();
      chk("rd_pulse_end", 32'(rd_valid), 32'd0);
      chk("rd_data_zero", rd_data, 32'd0);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      chk("rst_ready_low", 32'(ready), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_addr_err", 32'(addr_err), 32'd0);
      chk("rst_ctrl", ctrl, 32'd0);
      rstn = 1'b1;
      tick();
      chk("rst_ready_after", 32'(ready), 32'd1);
      do_read(32'h0, ID, 1'b0);
   endtask

   task automatic test_write_ctrl();
      do_write(32'h4, 32'h1234_5678, 1'b0);
      chk("ctrl_updated", ctrl, 32'h1234_5678);
      do_read(32'h4, 32'h1234_5678, 1'b0);
   endtask

   task automatic test_id_protect();
      do_write(32'h0, 32'hFFFF_FFFF, 1'b0);
      do_read(32'h0, ID, 1'b0);
   endtask

   task automatic test_out_of_range();
      do_write(32'h44, 32'hDEAD_BEEF, 1'b1);
      chk("oor_ctrl_kept", ctrl, 32'h1234_5678);
      do_read(32'h40, 32'h0, 1'b1);
      do_read(32'h4, 32'h1234_5678, 1'b0);
   endtask

   task automatic test_back_to_back();
      int n;
      valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h8; wdata = 32'hA5;
      tick();
      rd0_wr1 = 1'b0;
      chk("b2b_wr_ack", 32'(ready), 32'd0);
      tick();
      chk("b2b_ready_2nd", 32'(ready), 32'd1);
      tick();
      chk("b2b_rd_accepted", 32'(ready), 32'd0);
      valid = 1'b0;
      n = 1;
      while (!rd_valid && n < 20) begin
         tick();
         n++;
      end
      chk("b2b_latency", 32'(n), 32'd2);
      chk("b2b_data", rd_data, 32'hA5);
      tick();
   endtask

   task automatic test_rd_lat3();
      int n;
      valid3 = 1'b1; rd0_wr13 = 1'b1; addr3 = 32'h8; wdata3 = 32'h5A5A;
      tick();
      valid3 = 1'b0;
      chk("lat3_wr_ack", 32'(ready3), 32'd0);
      tick();
      chk("lat3_ready", 32'(ready3), 32'd1);
      valid3 = 1'b1; rd0_wr13 = 1'b0;
      tick();
      valid3 = 1'b0;
      n = 1;
      while (!rd_valid3 && n < 20) begin
         tick();
         n++;
      end
      chk("lat3_latency", 32'(n), 32'd4);
      chk("lat3_data", rd_data3, 32'h5A5A);
      tick();
      chk("lat3_pulse_end", 32'(rd_valid3), 32'd0);
   endtask

   task automatic test_reset_mid_read();
      int pulses;
      valid = 1'b1; rd0_wr1 = 1'b0; addr = 32'h4;
      tick();
      valid = 1'b0;
      rstn = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rd_valid) pulses++;
      end
      rstn = 1'b1;
      tick();
      if (rd_valid) pulses++;
      chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd1);
      chk("mid_rst_ctrl", ctrl, 32'd0);
      do_read(32'h4, 32'h0, 1'b0);
      do_read(32'h8, 32'h0, 1'b0);
   endtask

   initial begin
      rstn = 1'b0;
      valid = 1'b0; rd0_wr1 = 1'b0; addr = '0; wdata = '0;
      valid3 = 1'b0; rd0_wr13 = 1'b0; addr3 = '0; wdata3 = '0;
      tick();
      test_reset();
      test_write_ctrl();
      test_id_protect();
      test_out_of_range();
      test_back_to_back();
      test_rd_lat3();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
